// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the elastic pipeline-stage registers: field widths,
// the NOP opcode, per-stage payload widths, bubble payloads built from OP_NOP,
// and the occupancy state encoding used by pipe_stage_reg.
package pipe_pkg;

    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    localparam logic [OP_W-1:0] OP_NOP = 6'h00;

    // E->M payload: op, valE, valA, dstE, dstM
    localparam int E2M_W = OP_W + 2 * WORD_W + 2 * REG_W;
    // M->W payload: op, valE, valM, dstE, dstM
    localparam int M2W_W = OP_W + 2 * WORD_W + 2 * REG_W;

    // The opcode sits in the top bits of every packed payload, so a bubble is
    // a NOP opcode with all remaining fields zero.
    localparam logic [E2M_W-1:0] E2M_BUBBLE = {OP_NOP, {(E2M_W - OP_W){1'b0}}};
    localparam logic [M2W_W-1:0] M2W_BUBBLE = {OP_NOP, {(M2W_W - OP_W){1'b0}}};

    // Encoding doubles as the occ output value.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One storage slot of the stage register: a W-bit payload plus a valid bit.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clr        empty the slot (payload returns to BUBBLE_VAL); wins over load
//   load       capture load_data and mark the slot valid
//   load_data  payload to capture
//   valid      slot holds a live entry
//   data       held payload; BUBBLE_VAL whenever valid=0
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int             W          = E2M_W,
    parameter logic [W-1:0]   BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // NOTE: the payload register is reset along with the valid bit because
    // the main slot's payload is visible on out_data and must read as a
    // bubble, not as stale data, whenever the slot is empty.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst || clr) begin
            valid <= 1'b0;
            data  <= BUBBLE_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic pipeline-stage register with a two-entry skid buffer. Both sides use
// a valid/ready handshake; every output is driven straight from a flop.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous kill of all held and in-flight entries
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a live entry
//   out_ready  downstream consumes this cycle
//   out_data   head payload; BUBBLE_VAL when out_valid=0
//   occ        entries held, 0..2 (registered)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int           W          = E2M_W,
    parameter logic [W-1:0] BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    occ_state_e   state_q;
    occ_state_e   state_d;
    logic         rdy_q;

    logic         skid_valid;
    logic [W-1:0] skid_data;

    logic         accept;
    logic         consume;
    logic         main_load;
    logic         main_clr;
    logic [W-1:0] main_next;
    logic         skid_load;
    logic         skid_clr;

    // NOTE: every signal assigned here gets a value on every path (defaults
    // first in the case), so no latch can be inferred.
    always_comb begin
        accept  = in_valid & rdy_q;
        consume = out_valid & out_ready;

        // Main reloads when empty and fed, when its beat leaves and a new one
        // arrives, or when it drains and the skid entry moves forward.
        main_load = (accept & (!out_valid | consume)) | (consume & skid_valid);
        main_clr  = flush | (consume & !skid_valid & !accept);
        main_next = skid_valid ? skid_data : in_data;

        // Skid catches the beat that arrived while the head was stalled.
        skid_load = accept & out_valid & !consume;
        skid_clr  = flush | (consume & skid_valid);

        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (accept) state_d = OCC_ONE;
            OCC_ONE: begin
                if (accept && !consume)      state_d = OCC_FULL;
                else if (consume && !accept) state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (consume) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    // in_ready is held low through reset so nothing is accepted while rst is
    // high, and tracks "skid empty" from the first edge after reset onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b0;
        end else if (flush) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != OCC_FULL);
        end
    end

    pipe_slot #(.W(W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr       (main_clr),
        .load      (main_load),
        .load_data (main_next),
        .valid     (out_valid),
        .data      (out_data)
    );

    pipe_slot #(.W(W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (skid_clr),
        .load      (skid_load),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    assign in_ready = rdy_q;
    assign occ      = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg: directed vector table, hand-written
// reset sequences and a random run against a queue scoreboard.
module tb_pipe_stage_reg;

    localparam int          W   = 16;
    localparam logic [15:0] BUB = 16'hB0B0;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occ;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.W(W), .BUBBLE_VAL(BUB)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [15:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [1:0]  exp_occ;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] id,
                                input logic ordy, input logic ev, input logic [15:0] ed,
                                input logic [1:0] eo, input logic er);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_occ = eo; v.exp_ready = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [15:0] ed,
                               input logic [1:0] eo, input logic er);
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, " out_data"},  {16'd0, out_data},  {16'd0, ed});
        check({tag, " occ"},       {30'd0, occ},       {30'd0, eo});
        check({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, er});
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] sb[$];
        logic acc, con;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h0001; out_ready = 1'b0;

        // Reset held two cycles with a beat offered: nothing may be taken.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst%0d out_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("rst%0d out_data", i),  {16'd0, out_data},  {16'd0, BUB});
            check($sformatf("rst%0d occ", i),       {30'd0, occ},       32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_state("post_rst", 1'b0, BUB, 2'd0, 1'b1);

        // Streaming 1..8 with out_ready high.
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, 16'(k), 1, 1, 16'(k), 2'd1, 1));
        // Drain to bubble.
        vecs.push_back(mk(0, 0, 16'hFFFF, 1, 0, BUB, 2'd0, 1));
        // Backpressure: A, then stall while B and C are offered, then release.
        vecs.push_back(mk(0, 1, 16'h000A, 1, 1, 16'h000A, 2'd1, 1));
        vecs.push_back(mk(0, 1, 16'h000B, 0, 1, 16'h000A, 2'd2, 0));
        vecs.push_back(mk(0, 1, 16'h000C, 0, 1, 16'h000A, 2'd2, 0));
        vecs.push_back(mk(0, 1, 16'h000C, 0, 1, 16'h000A, 2'd2, 0));
        vecs.push_back(mk(0, 1, 16'h000C, 1, 1, 16'h000B, 2'd1, 1));
        vecs.push_back(mk(0, 1, 16'h000C, 1, 1, 16'h000C, 2'd1, 1));
        vecs.push_back(mk(0, 0, 16'h1234, 1, 0, BUB, 2'd0, 1));
        // Single beat 0x55 then bubble.
        vecs.push_back(mk(0, 1, 16'h0055, 1, 1, 16'h0055, 2'd1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, BUB, 2'd0, 1));
        // Fill to FULL, flush while a beat is offered.
        vecs.push_back(mk(0, 1, 16'h0011, 0, 1, 16'h0011, 2'd1, 1));
        vecs.push_back(mk(0, 1, 16'h0022, 0, 1, 16'h0011, 2'd2, 0));
        vecs.push_back(mk(1, 1, 16'h0033, 0, 0, BUB, 2'd0, 1));
        vecs.push_back(mk(0, 0, 16'h0033, 1, 0, BUB, 2'd0, 1));
        // Flush coinciding with accept and consume.
        vecs.push_back(mk(0, 1, 16'h0044, 0, 1, 16'h0044, 2'd1, 1));
        vecs.push_back(mk(1, 1, 16'h0066, 1, 0, BUB, 2'd0, 1));
        vecs.push_back(mk(0, 0, 16'h0066, 1, 0, BUB, 2'd0, 1));
        vecs.push_back(mk(0, 1, 16'h0077, 1, 1, 16'h0077, 2'd1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, BUB, 2'd0, 1));

        foreach (vecs[i]) begin
            flush = vecs[i].flush; in_valid = vecs[i].in_valid;
            in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_occ, vecs[i].exp_ready);
        end
        flush = 1'b0;

        // Reset in the middle of a FULL stage: both slots must be lost.
        in_valid = 1'b1; in_data = 16'h00A1; out_ready = 1'b0;
        step();
        in_data = 16'h00A2;
        step();
        check_state("midrst_full", 1'b1, 16'h00A1, 2'd2, 1'b0);
        rst = 1'b1; in_data = 16'h00A3;
        step();
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_data",  {16'd0, out_data},  {16'd0, BUB});
        check("midrst occ",       {30'd0, occ},       32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_state("midrst_after", 1'b0, BUB, 2'd0, 1'b1);
        in_valid = 1'b1; in_data = 16'h00A4; out_ready = 1'b1;
        step();
        check_state("midrst_new", 1'b1, 16'h00A4, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        check_state("midrst_idle", 1'b0, BUB, 2'd0, 1'b1);

        // Random traffic against a FIFO scoreboard.
        for (int c = 0; c < 10000; c++) begin
            flush     = ($urandom_range(63) == 0);
            in_valid  = ($urandom_range(9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(9) < 6);
            #0;
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con && sb.size() > 0) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (acc) sb.push_back(in_data);
            step();
            check($sformatf("rnd%0d occ", c), {30'd0, occ}, sb.size());
            check($sformatf("rnd%0d out_valid", c), {31'd0, out_valid},
                  {31'd0, sb.size() != 0});
            check($sformatf("rnd%0d out_data", c), {16'd0, out_data},
                  {16'd0, (sb.size() != 0) ? sb[0] : BUB});
            check($sformatf("rnd%0d in_ready", c), {31'd0, in_ready},
                  {31'd0, sb.size() < 2});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
